// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Groups the keypad pin signals and the decoded key outputs of
//   keypad_scanner so they travel as one bundle.
//   fila      : keypad rows, active-high (asynchronous to clk)
//   col       : one-hot active-high column drive
//   posicion  : last accepted key code, row*4 + col
//   opr       : debounced "key held" flag
//   nueva     : one-clock pulse per accepted press (and per auto-repeat)
//   dbg_state : current scanner FSM state, for observation only
//   master modport = the scanner, slave modport = pins/consumers side.
interface keypad_scanner_if;
    logic [3:0] fila;
    logic [3:0] col;
    logic [3:0] posicion;
    logic       opr;
    logic       nueva;
    logic [1:0] dbg_state;

    modport master (
        input  fila,
        output col,
        output posicion,
        output opr,
        output nueva,
        output dbg_state
    );

    modport slave (
        output fila,
        input  col,
        input  posicion,
        input  opr,
        input  nueva,
        input  dbg_state
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad one column at a time, picks the first
//   pressed key of each 4-column sweep, debounces press and release over
//   DEBOUNCE_SCANS sweeps and reports the key code plus a held flag.
//   Ports:
//     clk : system clock
//     rst : asynchronous active-low reset
//     kp  : keypad_scanner_if.master (fila in; col, posicion, opr, nueva,
//           dbg_state out)
//   Optional build macro KEY_REPEAT_EN: while a key stays held, nueva
//   pulses again every REPEAT_SCANS sweeps.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 10,
    parameter int REPEAT_SCANS   = 250
) (
    input logic              clk,
    input logic              rst,
    keypad_scanner_if.master kp
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE_SCANS);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [3:0]       fila_m_q, fila_s_q;
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic             hit_q, hit_d;
    logic [3:0]       code_q, code_d;
    logic [1:0]       state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    // Shared by DEBOUNCE (stable count) and RELEASE (release count); the
    // two states never overlap so one counter serves both.
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]       posicion_q, posicion_d;
    logic             opr_q, opr_d;
    logic             nueva_q, nueva_d;
`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_SCANS);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    logic            slot_end, sweep_end, row_hit, sweep_hit, key_present;
    logic [1:0]      row_idx;
    logic [3:0]      slot_code, sweep_code;
    logic [DB_W-1:0] db_inc;

    // Lowest row index wins within a column.
    always_comb begin
        row_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (fila_s_q[r]) row_idx = 2'(r);
        end
    end

    assign slot_end  = (slot_cnt_q == SLOT_LAST);
    assign sweep_end = slot_end && (col_idx_q == 2'd3);
    assign row_hit   = |fila_s_q;
    assign slot_code = {row_idx, col_idx_q};
    // Sweep result folds in the slot being sampled right now, so the
    // last column counts in the same cycle the sweep closes.
    assign sweep_hit   = hit_q | row_hit;
    assign sweep_code  = hit_q ? code_q : slot_code;
    assign key_present = sweep_hit && (sweep_code == posicion_q);
    assign db_inc      = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + DB_W'(1);

    always_comb begin
        slot_cnt_d = slot_end ? '0 : slot_cnt_q + CNT_W'(1);
        col_idx_d  = slot_end ? col_idx_q + 2'd1 : col_idx_q;
        hit_d      = hit_q;
        code_d     = code_q;
        state_d    = state_q;
        cand_d     = cand_q;
        db_cnt_d   = db_cnt_q;
        posicion_d = posicion_q;
        opr_d      = opr_q;
        nueva_d    = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt_d  = rep_cnt_q;
`endif

        if (slot_end) begin
            if (sweep_end) begin
                hit_d = 1'b0;
            end else if (!hit_q && row_hit) begin
                hit_d  = 1'b1;
                code_d = slot_code;
            end
        end

        if (sweep_end) begin
            case (state_q)
                ST_SCAN: begin
                    if (sweep_hit) begin
                        cand_d = sweep_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            posicion_d = sweep_code;
                            opr_d      = 1'b1;
                            nueva_d    = 1'b1;
                            state_d    = ST_HELD;
                            db_cnt_d   = '0;
`ifdef KEY_REPEAT_EN
                            rep_cnt_d  = '0;
`endif
                        end else begin
                            state_d  = ST_DEBOUNCE;
                            db_cnt_d = DB_W'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (sweep_hit && (sweep_code == cand_q)) begin
                        if (db_inc == DB_MAX) begin
                            posicion_d = cand_q;
                            opr_d      = 1'b1;
                            nueva_d    = 1'b1;
                            state_d    = ST_HELD;
                            db_cnt_d   = '0;
`ifdef KEY_REPEAT_EN
                            rep_cnt_d  = '0;
`endif
                        end else begin
                            db_cnt_d = db_inc;
                        end
                    end else begin
                        state_d  = ST_SCAN;
                        db_cnt_d = '0;
                    end
                end
                ST_HELD: begin
                    if (key_present) begin
`ifdef KEY_REPEAT_EN
                        if (rep_cnt_q + REP_W'(1) == REP_MAX) begin
                            nueva_d   = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_W'(1);
                        end
`endif
                    end else if (DEBOUNCE_SCANS == 1) begin
                        opr_d   = 1'b0;
                        state_d = ST_SCAN;
                    end else begin
                        state_d  = ST_RELEASE;
                        db_cnt_d = DB_W'(1);
                    end
                end
                default: begin // ST_RELEASE
                    if (key_present) begin
                        state_d  = ST_HELD;
                        db_cnt_d = '0;
`ifdef KEY_REPEAT_EN
                        rep_cnt_d = '0;
`endif
                    end else if (db_inc == DB_MAX) begin
                        opr_d    = 1'b0;
                        state_d  = ST_SCAN;
                        db_cnt_d = '0;
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fila_m_q   <= '0;
            fila_s_q   <= '0;
            slot_cnt_q <= '0;
            col_idx_q  <= '0;
            hit_q      <= 1'b0;
            code_q     <= '0;
            state_q    <= ST_SCAN;
            cand_q     <= '0;
            db_cnt_q   <= '0;
            posicion_q <= '0;
            opr_q      <= 1'b0;
            nueva_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt_q  <= '0;
`endif
        end else begin
            fila_m_q   <= kp.fila;
            fila_s_q   <= fila_m_q;
            slot_cnt_q <= slot_cnt_d;
            col_idx_q  <= col_idx_d;
            hit_q      <= hit_d;
            code_q     <= code_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            db_cnt_q   <= db_cnt_d;
            posicion_q <= posicion_d;
            opr_q      <= opr_d;
            nueva_q    <= nueva_d;
`ifdef KEY_REPEAT_EN
            rep_cnt_q  <= rep_cnt_d;
`endif
        end
    end

    assign kp.col       = 4'b0001 << col_idx_q;
    assign kp.posicion  = posicion_q;
    assign kp.opr       = opr_q;
    assign kp.nueva     = nueva_q;
    assign kp.dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Drives a simulated 4x4 keypad (set of pressed keys per sweep) into
//   keypad_scanner and compares opr / posicion / nueva after every sweep
//   against a sweep-level reference model of the press/release rules.
module tb_keypad_scanner;
  localparam int SCAN_DIV   = 4;
  localparam int DB         = 3;
  localparam int RS         = 5;
  localparam int SWEEP_CLKS = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] mask = '0;
  int          checks = 0;
  int          fails = 0;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_SCANS(DB),
    .REPEAT_SCANS(RS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp(kp.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Keypad matrix: a row reads high when a pressed key sits on a driven column.
  always_comb begin
    kp.fila = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (kp.col[c] && mask[r*4+c]) kp.fila[r] = 1'b1;
  end

  // ---------------- reference model (one step per sweep) ----------------
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  bit         m_held;
  logic [3:0] m_pos;
  int         m_run_key, m_run_len, m_abs_len, m_rep;

  task automatic model_reset();
    m_held = 0; m_pos = '0; m_run_key = -1; m_run_len = 0; m_abs_len = 0; m_rep = 0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic model_sweep(input logic [15:0] m);
    int first;
    first = -1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (first < 0 && m[r*4+c]) first = r*4 + c;
    if (!m_held) begin
      if (m_run_len == 0) begin
        if (first >= 0) begin m_run_key = first; m_run_len = 1; end
      end else if (first == m_run_key) m_run_len++;
      else m_run_len = 0;
      if (m_run_len == DB) begin
        m_held = 1; m_pos = 4'(m_run_key); exp_q.push_back(m_pos);
        m_abs_len = 0; m_rep = 0; m_run_len = 0;
      end
    end else if (first == int'(m_pos)) begin
      if (m_abs_len > 0) begin m_abs_len = 0; m_rep = 0; end
      else begin
`ifdef KEY_REPEAT_EN
        m_rep++;
        if (m_rep == RS) begin exp_q.push_back(m_pos); m_rep = 0; end
`endif
      end
    end else begin
      m_abs_len++;
      if (m_abs_len == DB) begin m_held = 0; m_abs_len = 0; m_run_len = 0; end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_sweep(input logic [15:0] m);
    mask = m;
    repeat (SWEEP_CLKS) begin
      @(posedge clk); #1;
      if (kp.nueva) got_q.push_back(kp.posicion);
    end
    model_sweep(m);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if (kp.col !== 4'b0001 || kp.opr !== 1'b0 || kp.nueva !== 1'b0 || kp.posicion !== 4'd0) begin
      fails++; $display("FAIL reset_initial: col=%b opr=%b nueva=%b pos=%0d exp 0001/0/0/0", kp.col, kp.opr, kp.nueva, kp.posicion);
    end
    @(negedge clk); rst = 1'b1; model_reset();
    for (int i = 0; i < 4; i++) run_sweep(16'h0004);
    checks++;
    if (kp.opr !== 1'b1 || kp.posicion !== 4'd2) begin
      fails++; $display("FAIL reset_preload: opr=%b pos=%0d exp 1/2", kp.opr, kp.posicion);
    end
    @(posedge clk); #2; rst = 1'b0; #1;
    checks++;
    if (kp.col !== 4'b0001) begin fails++; $display("FAIL reset_async_col: got %b exp 0001", kp.col); end
    checks++;
    if (kp.opr !== 1'b0) begin fails++; $display("FAIL reset_async_opr: got %b exp 0", kp.opr); end
    checks++;
    if (kp.nueva !== 1'b0) begin fails++; $display("FAIL reset_async_nueva: got %b exp 0", kp.nueva); end
    checks++;
    if (kp.posicion !== 4'd0) begin fails++; $display("FAIL reset_async_posicion: got %0d exp 0", kp.posicion); end
    mask = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1; model_reset();
  endtask

  task automatic test_col_rotation();
    logic [3:0] exp_col;
    for (int k = 1; k <= SWEEP_CLKS; k++) begin
      @(posedge clk); #1;
      exp_col = 4'b0001 << ((k / SCAN_DIV) % 4);
      checks++;
      if (kp.col !== exp_col) begin
        fails++; $display("FAIL col_rotation clk %0d: got %b exp %b", k, kp.col, exp_col);
      end
    end
    model_sweep(mask);
  endtask

  task automatic test_clean_press();
    logic [15:0] seq[$];
    seq = {16'h0, 16'h0, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0, 16'h0, 16'h0, 16'h0};
    foreach (seq[i]) begin
      run_sweep(seq[i]);
      checks++;
      if (kp.opr !== m_held || kp.posicion !== m_pos || got_q.size() != exp_q.size()) begin
        fails++; $display("FAIL clean_press sweep %0d: opr=%b exp %b pos=%0d exp %0d pulses=%0d exp %0d", i, kp.opr, m_held, kp.posicion, m_pos, got_q.size(), exp_q.size());
      end
      got_q.delete(); exp_q.delete();
      if (i == 4) begin
        checks++;
        if (kp.opr !== 1'b1 || kp.posicion !== 4'd10) begin
          fails++; $display("FAIL clean_press_accept: opr=%b pos=%0d exp 1/10", kp.opr, kp.posicion);
        end
      end
      if (i == 8) begin
        checks++;
        if (kp.opr !== 1'b0 || kp.posicion !== 4'd10) begin
          fails++; $display("FAIL clean_press_release: opr=%b pos=%0d exp 0/10", kp.opr, kp.posicion);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      run_sweep((i % 2 == 0) ? 16'h0010 : 16'h0000);
      pulses += got_q.size();
      checks++;
      if (kp.opr !== m_held || kp.posicion !== m_pos || got_q.size() != exp_q.size()) begin
        fails++; $display("FAIL bounce sweep %0d: opr=%b exp %b pos=%0d exp %0d pulses=%0d exp %0d", i, kp.opr, m_held, kp.posicion, m_pos, got_q.size(), exp_q.size());
      end
      got_q.delete(); exp_q.delete();
    end
    checks++;
    if (pulses != 0) begin fails++; $display("FAIL bounce_no_pulse: got %0d pulses exp 0", pulses); end
  endtask

  task automatic test_two_keys();
    logic [15:0] seq[$];
    seq = {16'h4020, 16'h4020, 16'h4020, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0, 16'h0, 16'h0};
    foreach (seq[i]) begin
      run_sweep(seq[i]);
      checks++;
      if (kp.opr !== m_held || kp.posicion !== m_pos || got_q.size() != exp_q.size()) begin
        fails++; $display("FAIL two_keys sweep %0d: opr=%b exp %b pos=%0d exp %0d pulses=%0d exp %0d", i, kp.opr, m_held, kp.posicion, m_pos, got_q.size(), exp_q.size());
      end
      got_q.delete(); exp_q.delete();
      if (i == 2 || i == 8) begin
        checks++;
        if (kp.opr !== 1'b1 || kp.posicion !== ((i == 2) ? 4'd5 : 4'd14)) begin
          fails++; $display("FAIL two_keys_accept sweep %0d: opr=%b pos=%0d exp 1/%0d", i, kp.opr, kp.posicion, (i == 2) ? 5 : 14);
        end
      end
      if (i == 5) begin
        checks++;
        if (kp.opr !== 1'b0) begin fails++; $display("FAIL two_keys_release: opr=%b exp 0", kp.opr); end
      end
    end
  endtask

  task automatic test_release_glitch();
    logic [15:0] seq[$];
    seq = {16'h0008, 16'h0008, 16'h0008, 16'h0008, 16'h0008, 16'h0, 16'h0008, 16'h0008, 16'h0008, 16'h0, 16'h0, 16'h0};
    foreach (seq[i]) begin
      run_sweep(seq[i]);
      checks++;
      if (kp.opr !== m_held || kp.posicion !== m_pos || got_q.size() != exp_q.size()) begin
        fails++; $display("FAIL release_glitch sweep %0d: opr=%b exp %b pos=%0d exp %0d pulses=%0d exp %0d", i, kp.opr, m_held, kp.posicion, m_pos, got_q.size(), exp_q.size());
      end
      got_q.delete(); exp_q.delete();
      if (i >= 2 && i <= 8) begin
        checks++;
        if (kp.opr !== 1'b1) begin fails++; $display("FAIL release_glitch_held sweep %0d: opr=%b exp 1", i, kp.opr); end
      end
    end
  endtask

  task automatic test_repeat();
    int pulses, exp_pulses;
    pulses = 0;
`ifdef KEY_REPEAT_EN
    exp_pulses = 4;
`else
    exp_pulses = 0;
`endif
    for (int i = 0; i < 3 + 20; i++) begin
      run_sweep(16'h0080);
      if (i >= 3) pulses += got_q.size();
      checks++;
      if (kp.opr !== m_held || kp.posicion !== m_pos || got_q.size() != exp_q.size()) begin
        fails++; $display("FAIL repeat sweep %0d: opr=%b exp %b pos=%0d exp %0d pulses=%0d exp %0d", i, kp.opr, m_held, kp.posicion, m_pos, got_q.size(), exp_q.size());
      end
      got_q.delete(); exp_q.delete();
    end
    checks++;
    if (pulses != exp_pulses || kp.posicion !== 4'd7) begin
      fails++; $display("FAIL repeat_count: pulses=%0d exp %0d pos=%0d exp 7", pulses, exp_pulses, kp.posicion);
    end
    for (int i = 0; i < 4; i++) run_sweep(16'h0);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [15:0] m;
    int          sweeps, len;
    sweeps = 0;
    while (sweeps < 80) begin
      case ($urandom_range(0, 3))
        0:       m = '0;
        1, 2:    m = 16'(1) << $urandom_range(0, 15);
        default: m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        run_sweep(($urandom_range(0, 7) == 0) ? 16'h0 : m);
        checks++;
        if (kp.opr !== m_held || kp.posicion !== m_pos || got_q.size() != exp_q.size()) begin
          fails++; $display("FAIL random sweep %0d: opr=%b exp %b pos=%0d exp %0d pulses=%0d exp %0d", sweeps, kp.opr, m_held, kp.posicion, m_pos, got_q.size(), exp_q.size());
        end
        got_q.delete(); exp_q.delete();
        sweeps++;
      end
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    model_reset();
    test_reset();
    test_col_rotation();
    test_clean_press();
    test_bounce();
    test_two_keys();
    test_release_glitch();
    test_repeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving columns one at a time and sampling the rows.
- Debounces the pressed key and reports its position (0-15) plus a held flag.
- Supplies the key position that the tone generator (posT) and the register bank write port consume.
- Sits between the FPGA keypad pins and the rest of the design.

Parameters:
- SCAN_DIV, 50000, clocks per column slot (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_SCANS, 10, number of consecutive full 4-column sweeps a key must be stable before press or release is accepted; minimum 1.
- REPEAT_SCANS, 250, sweeps between auto-repeat pulses (used only with KEY_REPEAT_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- fila  input  4  keypad rows. Active-high, pulled down externally. Asynchronous to clk.
- col  output  4  keypad column drive, one-hot, active-high.
- posicion  output  4  last accepted key: row_index*4 + col_index.
- opr  output  1  high while the accepted key is held (debounced).
- nueva  output  1  one-clock pulse when a press is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - col=4'b0001, posicion=0, opr=0, nueva=0.
  - All counters cleared, FSM in SCAN, synchronizer flops cleared.
  - Release of reset is seen on the next clk edge.
- Row input path: fila passes through a 2-flop synchronizer before any use.
- Column timing:
  - Slot counter counts 0..SCAN_DIV-1, then wraps.
  - col rotates left (0001->0010->0100->1000->0001) on the cycle the counter wraps.
  - Synchronized rows are sampled on count SCAN_DIV-1, i.e. at the end of each slot after settling.
- Sweep: 4 slots.
  - Per sweep, the first hit is recorded, giving candidate key code (row*4+col) and a hit flag.
  - Priority: lowest column slot scanned first within the sweep; within a column, lowest row index wins.
  - Multiple simultaneous keys therefore report only the lowest-priority-index key; others are ignored.
- FSM, evaluated at each sweep end:
  - SCAN
    - Hit -> DEBOUNCE, latch candidate, stable_cnt=1.
    - No hit -> stay.
  - DEBOUNCE
    - Same candidate hit -> stable_cnt++. When stable_cnt reaches DEBOUNCE_SCANS: posicion<=candidate, opr<=1, nueva pulses 1 clk, -> HELD.
    - Different key or no hit -> SCAN, stable_cnt=0.
  - HELD
    - Latched key still hit -> stay.
    - Latched key absent (no hit, or a different key only) -> RELEASE, rel_cnt=1.
  - RELEASE
    - Latched key absent -> rel_cnt++. When rel_cnt reaches DEBOUNCE_SCANS: opr<=0 -> SCAN.
    - Latched key reappears -> HELD, rel_cnt=0.
- Output timing:
  - Press acceptance latency: DEBOUNCE_SCANS sweeps after the first sweep that sees the key.
  - nueva and the opr rise occur on the same clock edge as the posicion update.
- posicion holds its value after release until the next accepted press (the tone keeps its last note).
- Counter widths are derived by $clog2. Counters saturate and never wrap within a state.
- While the FSM is in HELD or RELEASE, column scanning continues uninterrupted.

Optional Feature:
- Macro KEY_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter increments each sweep.
  - At REPEAT_SCANS, nueva pulses again for 1 clk and the counter clears.
  - The counter clears on entry to HELD.
  - posicion is unchanged by repeat pulses.
- Undefined: no repeat logic is synthesized; nueva pulses exactly once per accepted press.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=5):
- Reset: assert rst=0 mid-slot with a key held -> col=0001, opr=0, nueva=0, posicion=0 immediately, without waiting for a clock edge.
- Clean press: hold row 2 whenever col=0100 -> after 3 sweeps (48 clk plus sync latency) posicion=10, opr=1, single nueva pulse. Release -> opr=0 three sweeps later, posicion stays 10.
- Bounce: row 1 toggles on alternate sweeps with col=0001 -> never accepted, opr stays 0, nueva never pulses.
- Two keys: keys 5 and 14 held together -> posicion=5 accepted. Release 5 while 14 stays -> opr falls after 3 sweeps, then 14 is accepted 3 sweeps after that.
- Release glitch: in HELD, key absent for 1 sweep then back -> opr stays 1, no new nueva.
- KEY_REPEAT_EN defined: hold key 7 for 20 sweeps after acceptance -> 4 extra nueva pulses spaced 5 sweeps apart. Undefined: exactly 1 pulse.
